// File: rtl/blink_meter.sv
// Measures rise-to-rise period and high time of an asynchronous pulse input in clock cycles,
// publishing each result with a one-cycle strobe and tracking lock/timeout status.
module blink_meter #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StArmed, StTracking} state_e;

  state_e           state_q;
  logic             sync_q;
  logic             s_q;
  logic             s_d_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;

  // Two-flop synchronizer followed by one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s_q    <= 1'b0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sig_in;
      s_q    <= sync_q;
      s_d_q  <= s_q;
    end
  end

  assign rise = s_q & ~s_d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else if (rise) begin
      cnt_q  <= CntOne;
      hcnt_q <= CntOne;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntOne;
      end
      if (s_q && (hcnt_q != CntMax)) begin
        hcnt_q <= hcnt_q + CntOne;
      end
    end
  end

  // A rise always takes priority over the timeout compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StArmed;
          end
        end
        StArmed, StTracking: begin
          if (rise) begin
            state_q    <= StTracking;
            period     <= cnt_q;
            high_time  <= hcnt_q;
            meas_valid <= 1'b1;
            locked     <= 1'b1;
            timeout    <= 1'b0;
          end else if (cnt_q == TimeoutVal) begin
            state_q <= StIdle;
            locked  <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: waveform segment table, hand-written corner sequences and random
// waveforms, all checked cycle by cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_blink_meter;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned TMO   = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  always #4 clk = ~clk;

  blink_meter #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobes = 0;

  // Reference model: rises are timestamped, high time is the sum of the s samples since the
  // previous rise, timeout is elapsed cycles since the last rise.
  bit     m_sync, m_s, m_sd, m_active;
  longint cyc = 0;
  longint last_rise = 0;
  bit     s_win[$];
  longint e_period = 0, e_high = 0;
  logic   e_valid = 1'b0, e_locked = 1'b0, e_timeout = 1'b0;

  task automatic model_edge();
    bit     rise;
    longint sum;
    if (!rst_n) begin
      m_sync = 0; m_s = 0; m_sd = 0; m_active = 0;
      s_win.delete();
      e_period = 0; e_high = 0; e_valid = 0; e_locked = 0; e_timeout = 0;
    end else begin
      rise = m_s && !m_sd;
      e_valid = 1'b0;
      if (rise) begin
        if (m_active) begin
          sum = 0;
          foreach (s_win[i]) sum += s_win[i];
          e_period  = cyc - last_rise;
          e_high    = sum;
          e_valid   = 1'b1;
          e_locked  = 1'b1;
          e_timeout = 1'b0;
        end
        m_active  = 1;
        last_rise = cyc;
        s_win.delete();
        s_win.push_back(1'b1);
      end else begin
        s_win.push_back(m_s);
        if (m_active && (cyc - last_rise == longint'(TMO))) begin
          m_active  = 0;
          e_locked  = 1'b0;
          e_timeout = 1'b1;
        end
      end
      m_sd   = m_s;
      m_s    = m_sync;
      m_sync = sig_in;
    end
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: model and DUT both see the same edge, outputs compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    n_tests++;
    if (longint'(period) != e_period || longint'(high_time) != e_high ||
        meas_valid !== e_valid || locked !== e_locked || timeout !== e_timeout) begin
      n_fail++;
      $display("FAIL cycle %0d: got p=%0d h=%0d v=%b l=%b t=%b, expected p=%0d h=%0d v=%b l=%b t=%b",
               cyc, period, high_time, meas_valid, locked, timeout,
               e_period, e_high, e_valid, e_locked, e_timeout);
    end
    if (meas_valid === 1'b1) strobes++;
  endtask

  task automatic cycles(input int n, input logic v);
    sig_in = v;
    repeat (n) step();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      cycles(hi, 1'b1);
      cycles(lo, 1'b0);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, longint'(period) + longint'(high_time) + longint'(meas_valid) +
          longint'(locked) + longint'(timeout), 0);
  endtask

  // Drive high (optionally dropping low after 10 cycles) and count edges until timeout.
  task automatic wait_timeout(input string name, input bit drop);
    int k;
    k = 0;
    sig_in = 1'b1;
    while (timeout !== 1'b1 && k < 1200) begin
      if (drop && k == 10) sig_in = 1'b0;
      step();
      k++;
    end
    check(name, k, TMO + 3);
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_strobes;
    int exp_period;
    int exp_high;
  } seg_t;

  seg_t segs[5];

  initial begin
    segs[0] = '{hi: 10,  lo: 90,  reps: 10, exp_strobes: 9,  exp_period: 100, exp_high: 10};
    segs[1] = '{hi: 125, lo: 125, reps: 3,  exp_strobes: 3,  exp_period: 250, exp_high: 125};
    segs[2] = '{hi: 1,   lo: 1,   reps: 20, exp_strobes: 20, exp_period: 2,   exp_high: 1};
    segs[3] = '{hi: 3,   lo: 2,   reps: 6,  exp_strobes: 6,  exp_period: 5,   exp_high: 3};
    segs[4] = '{hi: 10,  lo: 90,  reps: 4,  exp_strobes: 4,  exp_period: 100, exp_high: 10};

    // Reset held while the input toggles.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = i[0];
      step();
      check_zero("reset_hold");
    end
    check("reset_strobes", strobes, 0);
    rst_n = 1'b1;
    cycles(5, 1'b0);

    // Segment table: steady wave, rate change, toggle, odd duty, back to 100/10.
    foreach (segs[i]) begin
      strobes = 0;
      wave(segs[i].hi, segs[i].lo, segs[i].reps);
      cycles(5, 1'b0);
      check($sformatf("seg%0d_strobes", i), strobes, segs[i].exp_strobes);
      check($sformatf("seg%0d_period", i), period, segs[i].exp_period);
      check($sformatf("seg%0d_high", i), high_time, segs[i].exp_high);
      check($sformatf("seg%0d_locked", i), locked, 1);
      check($sformatf("seg%0d_timeout", i), timeout, 0);
    end

    // Strobe lands on the third edge after the input is first sampled high, for one cycle.
    sig_in = 1'b1;
    step(); check("lat_e1", meas_valid, 0);
    step(); check("lat_e2", meas_valid, 0);
    step(); check("lat_e3", meas_valid, 1);
    step(); check("lat_e4", meas_valid, 0);
    cycles(6, 1'b1);
    cycles(90, 1'b0);

    // Stop low after a rise: timeout with last result held.
    wait_timeout("stall_timeout_delay", 1'b1);
    check("stall_locked", locked, 0);
    check("stall_period", period, 100);
    check("stall_high", high_time, 10);

    // Recovery: first rise arms, second publishes.
    strobes = 0;
    wave(10, 90, 2);
    cycles(5, 1'b0);
    check("recover_strobes", strobes, 1);
    check("recover_timeout", timeout, 0);
    check("recover_locked", locked, 1);

    // Stuck high from a fresh reset: arms only, then times out.
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    cycles(3, 1'b0);
    strobes = 0;
    wait_timeout("stuck_timeout_delay", 1'b0);
    check("stuck_strobes", strobes, 0);
    check("stuck_period", period, 0);
    cycles(20, 1'b0);

    // Reset in the middle of a high phase while tracking; input still high at release.
    wave(10, 90, 3);
    cycles(4, 1'b1);
    rst_n = 1'b0;
    step();
    check_zero("midreset_zero");
    step();
    rst_n = 1'b1;
    strobes = 0;
    cycles(6, 1'b1);
    cycles(50, 1'b0);
    check("midreset_arm_only", strobes, 0);
    check("midreset_locked", locked, 0);
    wave(10, 90, 1);
    cycles(5, 1'b0);
    check("midreset_strobes", strobes, 1);
    check("midreset_period", period, 56);
    check("midreset_high", high_time, 6);

    // Random waveforms with occasional stalls and resets.
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0;
        cycles($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end else if (r < 6) begin
        cycles($urandom_range(990, 1100), 1'($urandom_range(0, 1)));
      end else begin
        wave($urandom_range(1, 30), $urandom_range(1, 60), 1);
      end
    end
    cycles(10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_meter.md
# blink_meter

Measures the period and high time of an asynchronous pulse input (LED drive, blink pin, external strobe) in clock cycles. It is the receive-side counterpart of the blinky LED generator, used in-system to check blink rate and duty cycle. Per-period results are published with a one-cycle valid strobe, and a lock/timeout status is maintained.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the period and high-time counters and outputs.
- `TIMEOUT_CYCLES`, default 125_000_000: cycles without a rising edge before tracking is dropped. Must satisfy 2 ≤ `TIMEOUT_CYCLES` < 2^`CNT_W`−1.

**Ports**
- `clk`, input, 1: single clock; all logic runs on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `sig_in`, input, 1: asynchronous pulse input to measure.
- `period`, output, `CNT_W`: last measured rise-to-rise interval, in cycles.
- `high_time`, output, `CNT_W`: high cycles within that same interval.
- `meas_valid`, output, 1: one-cycle strobe when `period`/`high_time` update.
- `locked`, output, 1: at least one valid measurement since the last reset or timeout.
- `timeout`, output, 1: sticky flag; the input stalled for `TIMEOUT_CYCLES`.

## Operation

- **Input conditioning**
  - 2-flop synchronizer gives `s`; a further flop gives `s_d`.
  - `rise = s & ~s_d`.
- **Counters**
  - `cnt`: on `rise`, load 1; otherwise increment, saturating at all-ones.
  - `hcnt`: on `rise`, load 1; otherwise increment when `s`=1, saturating at all-ones.
  - Both count in every state.
- **FSM states**
  - IDLE: waiting for the first edge.
  - ARMED: one edge seen.
  - TRACKING: measurements flowing.
- **FSM transitions**
  - IDLE, `rise` → ARMED. No publish.
  - ARMED, `rise` → TRACKING. Publish: `period`←`cnt`, `high_time`←`hcnt`, `meas_valid`←1, `locked`←1, `timeout`←0.
  - TRACKING, `rise` → publish again; stay in TRACKING.
  - ARMED or TRACKING, no `rise` and `cnt` == `TIMEOUT_CYCLES` → IDLE, `locked`←0, `timeout`←1. `period`/`high_time` hold their last values.
  - In IDLE the timeout compare is ignored; `timeout` holds.
  - `rise` in the same cycle as the timeout compare: `rise` wins and no timeout is taken.
- **Result semantics**
  - Rise events at cycles t0 and t0+N give `period`=N.
  - `high_time` = number of cycles in [t0, t0+N−1] with `s`=1, so 1 ≤ `high_time` ≤ N.
  - Minimum measurable period is 2.
- **Reset** (`rst_n`=0 at a clock edge) clears, regardless of state:
  - synchronizer flops, `s_d`, `cnt`, `hcnt`;
  - FSM → IDLE;
  - all outputs to 0.
- A `sig_in` already high at reset release produces a `rise`. This only arms (IDLE→ARMED) and never publishes.

## Timing

- All outputs are registered.
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0.
- Latency: `sig_in` first sampled high at edge E1 → `rise` during the cycle after edge E2 → outputs updated at edge E3. `meas_valid` is high for exactly one cycle following E3.
- `meas_valid` never asserts on consecutive cycles (period ≥ 2).
- `locked` and `timeout` are mutually exclusive at all times.
- Timeout fires at the edge where `cnt` == `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` cycles after the last `rise`.
- Pulses shorter than one clock may be missed; this is acceptable and not flagged.

## Test plan

All scenarios use a 125 MHz clk, `TIMEOUT_CYCLES`=1000 and `CNT_W`=32.

1. **Reset:** hold `rst_n`=0 for 5 cycles while `sig_in` toggles → all outputs 0 throughout; no `meas_valid`.
2. **Steady wave:** square wave, period 100 cycles, high 10 → first rise gives no strobe. Each later rise gives a strobe 3 cycles after the edge with `period`=100 and `high_time`=10; `locked`=1 from the first strobe. Over 10 periods: exactly 9 strobes.
3. **Rate change:** switch 100/10 to 250/125 mid-stream → next strobe reports `period`=250, `high_time`=125. No spurious strobes and `locked` stays 1.
4. **Timeout and recovery:** stop the wave low after a rise → exactly 1000 cycles after that rise, `locked`=0 and `timeout`=1, with `period`=100 held. Restart the wave → first rise gives no strobe; second rise strobes, `timeout`=0, `locked`=1.
5. **Stuck high:** `sig_in` goes high and stays high → no strobe; timeout after 1000 cycles.
6. **Boundaries:**
   - Toggle every cycle → `period`=2, `high_time`=1.
   - Reset mid-period → all outputs 0; first post-reset rise arms only.
